// File: rtl/lcd_text_fifo.sv
// lcd_text_fifo: byte FIFO and LCD cursor tracker that feeds lcd_ctrl via val/rdy
// Ports: clk, rst_n (asynchronous, active-low)
//   in_val/in_rdy/in_char : producer byte stream, in_rdy = !full
//   out_val/out_rdy/out_bits : lcd_ctrl side; char, 0xFF = clear, 0xC0 = move to line 1 col 0
//   level : FIFO occupancy
// Define LCD_AUTOWRAP_EN to continue text past column COLS-1 on the next line.
module lcd_text_fifo #(
  parameter int DEPTH = 32,
  parameter int COLS  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_val,
  output logic                       in_rdy,
  input  logic [7:0]                 in_char,
  input  logic                       out_rdy,
  output logic                       out_val,
  output logic [7:0]                 out_bits,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(COLS + 1);
`ifdef LCD_AUTOWRAP_EN
  typedef enum logic [1:0] {IDLE, SEND, WRAP, SEND2} state_t;
`else
  typedef enum logic {IDLE, SEND} state_t;
`endif
  state_t        r_state, w_state_nx;
  logic [7:0]    r_mem [DEPTH];
  logic [LW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_out_val, w_out_val_nx;
  logic [7:0]    r_out_bits, w_out_bits_nx, w_head, w_nl_cmd;
  logic          r_line, w_line_nx, w_adv_line;
  logic [CW-1:0] r_col, w_col_nx, w_adv_col;
  logic          w_pop, w_push, w_xfer, w_print, w_room, w_empty;
  assign level    = r_wr_ptr - r_rd_ptr;
  assign in_rdy   = level != LW'(DEPTH);
  assign w_empty  = level == '0;
  assign w_push   = in_val && in_rdy;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_xfer   = r_out_val && out_rdy;
  assign w_print  = w_head >= 8'h20 && w_head <= 8'h7E;
  assign w_room   = r_col < CW'(COLS);
  // a newline on line 1 clears the screen instead of moving to a nonexistent line 2
  assign w_nl_cmd = r_line ? 8'hFF : 8'hC0;
  // cursor once the command now held in out_bits has been accepted by lcd_ctrl
  assign w_adv_line = (r_out_bits == 8'hFF) ? 1'b0 : (r_out_bits == 8'hC0) ? 1'b1 : r_line;
  assign w_adv_col  = (r_out_bits == 8'hFF || r_out_bits == 8'hC0) ? '0 : w_room ? r_col + CW'(1) : r_col;
  assign out_val  = r_out_val;
  assign out_bits = r_out_bits;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_char;
  end
  always_comb begin
    w_state_nx    = r_state;
    w_out_val_nx  = r_out_val;
    w_out_bits_nx = r_out_bits;
    w_line_nx     = r_line;
    w_col_nx      = r_col;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_out_val_nx = 1'b1;
        w_state_nx   = SEND;
        if (w_print && w_room) w_out_bits_nx = w_head;
        else if (w_head == 8'h0A) w_out_bits_nx = w_nl_cmd;
        else if (w_head == 8'h0C || w_head == 8'hFF) w_out_bits_nx = 8'hFF;
`ifdef LCD_AUTOWRAP_EN
        else if (w_print) begin
          w_out_bits_nx = w_nl_cmd;
          w_state_nx    = WRAP;
        end
`endif
        else begin
          w_out_val_nx = 1'b0;
          w_state_nx   = IDLE;
          w_pop        = 1'b1;
        end
      end
      SEND: if (w_xfer) begin
        w_pop        = 1'b1;
        w_out_val_nx = 1'b0;
        w_line_nx    = w_adv_line;
        w_col_nx     = w_adv_col;
        w_state_nx   = IDLE;
      end
`ifdef LCD_AUTOWRAP_EN
      // the wrapped char stays at the FIFO head until it is sent from SEND2
      WRAP: if (w_xfer) begin
        w_out_val_nx = 1'b0;
        w_line_nx    = w_adv_line;
        w_col_nx     = w_adv_col;
        w_state_nx   = SEND2;
      end
      SEND2: if (!r_out_val) begin
        w_out_val_nx  = 1'b1;
        w_out_bits_nx = w_head;
      end else if (w_xfer) begin
        w_pop        = 1'b1;
        w_out_val_nx = 1'b0;
        w_col_nx     = CW'(1);
        w_state_nx   = IDLE;
      end
`endif
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_out_val  <= 1'b0;
      r_out_bits <= '0;
      r_line     <= 1'b0;
      r_col      <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_ptr   <= r_wr_ptr + LW'(w_push);
      r_rd_ptr   <= r_rd_ptr + LW'(w_pop);
      r_out_val  <= w_out_val_nx;
      r_out_bits <= w_out_bits_nx;
      r_line     <= w_line_nx;
      r_col      <= w_col_nx;
    end
  end
endmodule

// File: tb/tb_lcd_text_fifo.sv
// tb_lcd_text_fifo: directed and random checks of lcd_text_fifo against a text-cursor model
module tb_lcd_text_fifo;
  localparam int DEPTH = 32;
  localparam int COLS  = 16;
  logic       clk = 0, rst_n = 0, in_val = 0, out_rdy = 1;
  logic [7:0] in_char = 0;
  logic       in_rdy, out_val;
  logic [7:0] out_bits;
  logic [5:0] level;
  int         checks = 0, failures = 0;
  logic [7:0] got[$], exp[$];
  int         m_line = 0, m_col = 0;
  bit         rnd = 0;
  logic       p_hold = 0;
  logic [7:0] p_bits = 0;
  always #5 clk = ~clk;
  lcd_text_fifo #(.DEPTH(DEPTH), .COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_rdy(in_rdy), .in_char(in_char),
    .out_rdy(out_rdy), .out_val(out_val), .out_bits(out_bits), .level(level)
  );
  always @(posedge clk) begin
    if (!rst_n) p_hold = 0;
    else begin
      if (p_hold) begin
        checks++;
        assert (out_bits === p_bits) else begin
          failures++;
          $error("FAIL hold_stable observed=%02h expected=%02h", out_bits, p_bits);
        end
      end
      if (out_val && out_rdy) got.push_back(out_bits);
      p_hold = out_val && !out_rdy;
      p_bits = out_bits;
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (rnd) out_rdy = 1'($urandom_range(0, 1));
  endtask
  task automatic newline();
    exp.push_back(m_line == 0 ? 8'hC0 : 8'hFF);
    m_line = m_line == 0 ? 1 : 0;
    m_col  = 0;
  endtask
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (m_col < COLS) begin
        exp.push_back(b);
        m_col++;
      end
`ifdef LCD_AUTOWRAP_EN
      else begin
        newline();
        exp.push_back(b);
        m_col = 1;
      end
`endif
    end else if (b == 8'h0A) newline();
    else if (b == 8'h0C || b == 8'hFF) begin
      exp.push_back(8'hFF);
      m_line = 0;
      m_col  = 0;
    end
  endtask
  task automatic push(input logic [7:0] b);
    int t = 0;
    tick();
    in_val  = 1;
    in_char = b;
    while (!in_rdy && t < 5000) begin
      tick();
      t++;
    end
    chk("push_accept", in_rdy, 1);
    @(posedge clk);
    #1 in_val = 0;
    if (t < 5000) model(b);
  endtask
  task automatic try_push(input logic [7:0] b, output bit acc);
    tick();
    in_val  = 1;
    in_char = b;
    acc     = in_rdy;
    @(posedge clk);
    #1 in_val = 0;
    if (acc) model(b);
  endtask
  task automatic check_stream(input string tag);
    int t = 0;
    while (!(got.size() >= exp.size() && level == 0 && !out_val) && t < 20000) begin
      tick();
      t++;
    end
    repeat (4) tick();
    chk({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_line"}, dut.r_line, m_line);
    chk({tag, "_col"}, dut.r_col, m_col);
    got.delete();
    exp.delete();
  endtask
  initial begin
    bit         acc;
    int         nacc, t;
    logic [7:0] first, b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_val", out_val, 0);
    chk("rst_level", level, 0);
    chk("rst_out_bits", out_bits, 0);
    @(negedge clk) rst_n = 1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_col", dut.r_col, 0);
    chk("rst_line", dut.r_line, 0);
    push("H"); push("i");
    check_stream("hi");
    push("A"); push(8'h0A); push("B");
    check_stream("nl");
    push(8'h0A); push("Z");
    check_stream("clr");
    push(8'h07); push(8'h9A);
    check_stream("ctrl");
    push(8'h0C);
    check_stream("home");
    for (int i = 0; i < 17; i++) push("x");
    check_stream("overflow");
    push(8'h0C);
    check_stream("home2");
    out_rdy = 0;
    nacc = 0;
    first = 0;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(32, 126));
      if (i == 0) first = b;
      try_push(b, acc);
      if (acc) nacc++;
    end
    chk("stall_accepted", nacc, DEPTH);
    chk("stall_level", level, DEPTH);
    chk("stall_in_rdy", in_rdy, 0);
    repeat (3) tick();
    chk("stall_out_val", out_val, 1);
    chk("stall_out_bits", out_bits, first);
    out_rdy = 1;
    check_stream("stall");
    rnd = 1;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'($urandom_range(32, 126));
        6: b = 8'h0A;
        7: b = 8'h0C;
        8: b = 8'hFF;
        default: b = $urandom_range(0, 1) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(128, 254));
      endcase
      if (b == 8'h0A || b == 8'h0C) b = $urandom_range(0, 3) == 0 ? b : 8'($urandom_range(32, 126));
      push(b);
    end
    check_stream("random");
    rnd = 0;
    out_rdy = 0;
    push("Q"); push("R");
    t = 0;
    while (!out_val && t < 100) begin
      tick();
      t++;
    end
    chk("pre_rst_out_val", out_val, 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out_val", out_val, 0);
    chk("async_rst_level", level, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    m_line = 0;
    m_col  = 0;
    got.delete();
    exp.delete();
    chk("post_rst_out_val", out_val, 0);
    chk("post_rst_line", dut.r_line, 0);
    chk("post_rst_col", dut.r_col, 0);
    out_rdy = 1;
    push("O"); push("K");
    check_stream("after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
